// File: rtl/split_arbiter.sv
// split_arbiter: round-robin share of one DATA_W -> DATA_W/2 split path.
// The granted word is held, then emitted as low half followed by high half
// on a single valid/ready beat stream.
module split_arbiter #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned DATA_W  = 32,
   localparam int unsigned HW     = DATA_W / 2,
   localparam int unsigned SRC_W  = $clog2(NUM_REQ)
) (
   input  logic                      clock,
   input  logic                      reset_n,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic                      out_valid,
   output logic [HW-1:0]             out_data,
   output logic                      out_last,
   output logic [SRC_W-1:0]          out_src,
   input  logic                      out_ready,
   output logic                      busy
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SEND_LO = 2'd1,
      SEND_HI = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [DATA_W-1:0]   hold_q, hold_d;
   logic [SRC_W-1:0]    last_grant_q, last_grant_d;
   logic [SRC_W-1:0]    out_src_q, out_src_d;
   logic                out_valid_q, out_valid_d;
   logic                out_last_q, out_last_d;
   logic [HW-1:0]       out_data_q, out_data_d;
   logic                busy_q, busy_d;

   logic                grant_found;
   logic [SRC_W-1:0]    grant_idx;

   // Round-robin search: first valid requester after last_grant, wrapping.
   always_comb begin : rr_search
      int unsigned idx;
      grant_found = 1'b0;
      grant_idx   = '0;
      idx         = 0;
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         idx = (32'(last_grant_q) + k) % NUM_REQ;
         if (!grant_found && req_valid[SRC_W'(idx)]) begin
            grant_found = 1'b1;
            grant_idx   = SRC_W'(idx);
         end
      end
   end

   // Next-state, capture and registered-output next values.
   always_comb begin
      state_d      = state_q;
      hold_d       = hold_q;
      last_grant_d = last_grant_q;
      out_src_d    = out_src_q;
      req_ready    = '0;

      case (state_q)
         IDLE: begin
            if (grant_found) begin
               req_ready    = NUM_REQ'(1) << grant_idx;
               hold_d       = req_data[32'(grant_idx)*DATA_W +: DATA_W];
               out_src_d    = grant_idx;
               last_grant_d = grant_idx;
               state_d      = SEND_LO;
            end
         end
         SEND_LO: begin
            if (out_ready) begin
               state_d = SEND_HI;
            end
         end
         SEND_HI: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      out_valid_d = (state_d != IDLE);
      busy_d      = (state_d != IDLE);
      out_last_d  = (state_d == SEND_HI);
      if (state_d == SEND_LO) begin
         out_data_d = hold_d[HW-1:0];
      end else if (state_d == SEND_HI) begin
         out_data_d = hold_d[DATA_W-1:HW];
      end else begin
         out_data_d = '0;
      end
   end

   // State, hold register and output registers; reset aborts any word.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         hold_q       <= '0;
         last_grant_q <= SRC_W'(NUM_REQ - 1);
         out_src_q    <= '0;
         out_valid_q  <= 1'b0;
         out_last_q   <= 1'b0;
         out_data_q   <= '0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         hold_q       <= hold_d;
         last_grant_q <= last_grant_d;
         out_src_q    <= out_src_d;
         out_valid_q  <= out_valid_d;
         out_last_q   <= out_last_d;
         out_data_q   <= out_data_d;
         busy_q       <= busy_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_last  = out_last_q;
   assign out_src   = out_src_q;
   assign busy      = busy_q;

endmodule

// File: doc/split_arbiter.md
Name: split_arbiter

Overview:
- Shares one 32-to-16 split path between NUM_REQ requesters.
- Round-robin arbitration picks one requester, captures its DATA_W-bit word, then sends it as two half-width beats on one valid/ready output: low half first, then high half.
- Sits between the requester data sources and the downstream 16-bit consumer, and sequences the split.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..16.
- DATA_W, 32, input word width; must be even. Half width HW = DATA_W/2 (derived, not overridable).
- SRC_W, $clog2(NUM_REQ), width of the source-index output (derived).

Ports:
- clock  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- req_valid  input  NUM_REQ  per-requester word-valid.
- req_data  input  NUM_REQ*DATA_W  packed words; requester i uses bits [i*DATA_W +: DATA_W].
- req_ready  output  NUM_REQ  one-hot grant/accept, combinational.
- out_valid  output  1  half-word beat valid.
- out_data  output  HW  half-word beat.
- out_last  output  1  high in the high-half beat.
- out_src  output  SRC_W  index of the requester that owns the current beat.
- out_ready  input  1  downstream accept.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- FSM states: IDLE, SEND_LO, SEND_HI.
- Reset, asynchronous on negedge reset_n:
  - state = IDLE; hold register = 0; out_src = 0.
  - last_grant = NUM_REQ-1, so requester 0 has first priority.
  - out_valid, out_last and busy = 0; out_data = 0.
- IDLE:
  - Grant g is the first i with req_valid[i]=1, searching from last_grant+1 upward and wrapping modulo NUM_REQ.
  - If any req_valid is high: req_ready = one-hot(g) in the same cycle. At the clock edge, hold <= req_data[g], out_src <= g, last_grant <= g, and the FSM moves to SEND_LO.
  - If no req_valid is high: req_ready = 0 and the FSM stays in IDLE.
- SEND_LO: out_valid=1, out_data=hold[HW-1:0], out_last=0. If out_ready, go to SEND_HI; otherwise hold and keep all outputs stable.
- SEND_HI: out_valid=1, out_data=hold[DATA_W-1:HW], out_last=1. If out_ready, go to IDLE; otherwise hold.
- req_ready is 0 in SEND_LO and SEND_HI.
- Latency and throughput:
  - The first beat is visible the cycle after the accept.
  - One word takes at least 3 cycles (accept, LO, HI). The IDLE bubble between words is intended.
- out_data, out_last and out_src must not change while out_valid=1 and out_ready=0.
- Requester rules:
  - A requester holds req_data stable while req_valid=1.
  - If a requester drops req_valid before it is granted, nothing is captured for it. This is legal.
- Fairness:
  - With all requesters continuously valid, the grant order is 0,1,2,3,0,...
  - No requester waits more than NUM_REQ-1 grants.
- A single requester that stays valid is granted every word; its own index does not block it.
- out_ready high in IDLE has no effect.
- Reset asserted mid-word aborts the word. Outputs go to their reset values immediately (asynchronously), and the remaining half is never sent.
- No combinational path from out_ready to req_ready.

Test Plan:
- Reset release, req_valid=0001, req_data[0]=0xDEADBEEF, out_ready=1:
  - req_ready=0001 for 1 cycle.
  - Then beat 0xBEEF (last=0, src=0), then beat 0xDEAD (last=1, src=0).
  - busy falls after the HI beat.
- All four valid and held, words 0x1111AAAA, 0x2222BBBB, 0x3333CCCC, 0x4444DDDD, out_ready=1:
  - Grants 0,1,2,3,0.
  - Beats AAAA,1111,BBBB,2222,CCCC,3333,DDDD,4444 with src 0,0,1,1,2,2,3,3.
  - Each word occupies 3 cycles.
- Backpressure: out_ready=0 for 5 cycles during SEND_LO, then during SEND_HI:
  - out_data, out_src and out_last stay constant.
  - No new req_ready; no beat is lost or duplicated.
- Fairness after a grant: last_grant=2, requesters 0 and 3 valid -> requester 3 is granted before requester 0.
- reset_n low while in SEND_HI with word 0x12345678:
  - out_valid drops to 0 asynchronously; state is IDLE.
  - After release the 0x1234 beat is never emitted, and requester 0 is granted first.
- Single requester 2 continuously valid with an incrementing word:
  - Granted on every IDLE cycle.
  - The output sequence is gap-free apart from the one IDLE bubble per word.
